gvt_sequencer: RTL and testbench

GVT_SEQUENCER -- requirements
Module: gvt_sequencer

---
 rtl/chronos_pkg.sv | 24 ++
 rtl/vt_min.sv | 24 ++
 rtl/gvt_sequencer.sv | 160 ++++++++++++++++
 tb/tb_gvt_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chronos_pkg.sv
// Shared chronos definitions for the GVT sequencer: the virtual-time record,
// its infinity value and the sequencer FSM state encoding.
`timescale 1ns/1ps
package chronos_pkg;

    // Virtual time at the default widths: timestamp first, tiebreaker second.
    // Ordering is lexicographic, so {ts,tb} compares as one unsigned vector.
    typedef struct packed {
        logic [31:0] ts;
        logic [31:0] tb;
    } vt_t;

    // All-ones is "infinity"; it simply loses every comparison.
    localparam vt_t VT_INF = '{ts: '1, tb: '1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        COLLECT = 3'd2,
        REDUCE  = 3'd3,
        PUBLISH = 3'd4
    } gvt_state_t;

endpackage

// File: rtl/vt_min.sv
// Combinational lexicographic minimum of two virtual times. a wins only when
// strictly smaller, so equal inputs return b.
`timescale 1ns/1ps
module vt_min #(
    parameter int TS_WIDTH = 32,
    parameter int TB_WIDTH = 32
) (
    input  logic [TS_WIDTH-1:0] a_ts,
    input  logic [TB_WIDTH-1:0] a_tb,
    input  logic [TS_WIDTH-1:0] b_ts,
    input  logic [TB_WIDTH-1:0] b_tb,
    output logic [TS_WIDTH-1:0] min_ts,
    output logic [TB_WIDTH-1:0] min_tb,
    output logic                a_lt_b
);

    // Timestamp decides first; the tiebreaker only matters on equal timestamps.
    always_comb begin
        a_lt_b = (a_ts < b_ts) || ((a_ts == b_ts) && (a_tb < b_tb));
        min_ts = a_lt_b ? a_ts : b_ts;
        min_tb = a_lt_b ? a_tb : b_tb;
    end

endmodule

// File: rtl/gvt_sequencer.sv
// GVT sequencer: periodically broadcasts an LVT request, collects one response
// per tile, reduces them serially to the lexicographic minimum and publishes it.
// Optional macro GVT_MONOTONIC_CHECK_EN: refuse to publish a GVT that moves
// backwards and raise the sticky gvt_err flag instead.
`timescale 1ns/1ps
module gvt_sequencer
    import chronos_pkg::*;
#(
    parameter int N_TILES        = 8,
    parameter int TS_WIDTH       = 32,
    parameter int TB_WIDTH       = 32,
    parameter int EPOCH_WIDTH    = 8,
    parameter int LOG_GVT_PERIOD = 5
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               gvt_hold,
    output logic                               lvt_req,
    input  logic [N_TILES-1:0]                 tile_lvt_valid,
    input  logic [N_TILES-1:0][TS_WIDTH-1:0]   tile_lvt_ts,
    input  logic [N_TILES-1:0][TB_WIDTH-1:0]   tile_lvt_tb,
    output logic [TS_WIDTH-1:0]                gvt_ts,
    output logic [TB_WIDTH-1:0]                gvt_tb,
    output logic                               gvt_valid,
    output logic [EPOCH_WIDTH-1:0]             gvt_epoch,
    output logic                               gvt_err
);

    localparam int                IDX_W    = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_TILES - 1);

    gvt_state_t                       state;
    logic [LOG_GVT_PERIOD-1:0]        period_cnt;
    logic [N_TILES-1:0]               done;
    logic [N_TILES-1:0][TS_WIDTH-1:0] lat_ts;
    logic [N_TILES-1:0][TB_WIDTH-1:0] lat_tb;
    logic [IDX_W-1:0]                 idx;
    logic [TS_WIDTH-1:0]              min_ts;
    logic [TB_WIDTH-1:0]              min_tb;
    logic [TS_WIDTH-1:0]              scan_ts;
    logic [TB_WIDTH-1:0]              scan_tb;
    logic                             reduce_lt_unused;

    // Running minimum against the tile currently selected by the scan index.
    vt_min #(.TS_WIDTH(TS_WIDTH), .TB_WIDTH(TB_WIDTH)) u_reduce (
        .a_ts   (lat_ts[idx]),
        .a_tb   (lat_tb[idx]),
        .b_ts   (min_ts),
        .b_tb   (min_tb),
        .min_ts (scan_ts),
        .min_tb (scan_tb),
        .a_lt_b (reduce_lt_unused)
    );

`ifdef GVT_MONOTONIC_CHECK_EN
    logic                err_q;
    logic                regress;
    logic [TS_WIDTH-1:0] chk_ts_unused;
    logic [TB_WIDTH-1:0] chk_tb_unused;

    // A new minimum strictly below the published GVT is a regression.
    vt_min #(.TS_WIDTH(TS_WIDTH), .TB_WIDTH(TB_WIDTH)) u_check (
        .a_ts   (min_ts),
        .a_tb   (min_tb),
        .b_ts   (gvt_ts),
        .b_tb   (gvt_tb),
        .min_ts (chk_ts_unused),
        .min_tb (chk_tb_unused),
        .a_lt_b (regress)
    );

    assign gvt_err = err_q;
`else
    assign gvt_err = 1'b0;
`endif

    // Round sequencing FSM with all outputs registered. gvt_hold is only
    // looked at in IDLE, so a round in flight always runs to completion.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            period_cnt <= '0;
            done       <= '0;
            lat_ts     <= '0;
            lat_tb     <= '0;
            idx        <= '0;
            min_ts     <= '1;
            min_tb     <= '1;
            lvt_req    <= 1'b0;
            gvt_ts     <= '0;
            gvt_tb     <= '0;
            gvt_valid  <= 1'b0;
            gvt_epoch  <= '0;
`ifdef GVT_MONOTONIC_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!gvt_hold) begin
                        if (period_cnt == '1) begin
                            period_cnt <= '0;
                            lvt_req    <= 1'b1;
                            state      <= REQ;
                        end else begin
                            period_cnt <= period_cnt + 1'b1;
                        end
                    end
                end
                REQ: begin
                    lvt_req <= 1'b0;
                    done    <= '0;
                    state   <= COLLECT;
                end
                COLLECT: begin
                    // First response per tile wins; repeats are dropped.
                    for (int i = 0; i < N_TILES; i++) begin
                        if (tile_lvt_valid[i] && !done[i]) begin
                            lat_ts[i] <= tile_lvt_ts[i];
                            lat_tb[i] <= tile_lvt_tb[i];
                            done[i]   <= 1'b1;
                        end
                    end
                    if (&done) begin
                        idx    <= '0;
                        min_ts <= '1;
                        min_tb <= '1;
                        state  <= REDUCE;
                    end
                end
                REDUCE: begin
                    min_ts <= scan_ts;
                    min_tb <= scan_tb;
                    idx    <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= PUBLISH;
                    end
                end
                PUBLISH: begin
`ifdef GVT_MONOTONIC_CHECK_EN
                    if (gvt_valid && regress) begin
                        err_q <= 1'b1;
                    end else begin
                        gvt_ts <= min_ts;
                        gvt_tb <= min_tb;
                    end
`else
                    gvt_ts <= min_ts;
                    gvt_tb <= min_tb;
`endif
                    gvt_valid <= 1'b1;
                    gvt_epoch <= gvt_epoch + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gvt_sequencer.sv
// Directed bench for gvt_sequencer (N_TILES=8, LOG_GVT_PERIOD=5).
`timescale 1ns/1ps
module tb_gvt_sequencer;

    localparam int N    = 8;
    localparam int TSW  = 32;
    localparam int TBW  = 32;
    localparam int EW   = 8;
    localparam int LOGP = 5;
`ifdef GVT_MONOTONIC_CHECK_EN
    localparam bit MONO = 1'b1;
`else
    localparam bit MONO = 1'b0;
`endif

    logic                    clk;
    logic                    rstn;
    logic                    gvt_hold;
    logic                    lvt_req;
    logic [N-1:0]            tile_lvt_valid;
    logic [N-1:0][TSW-1:0]   tile_lvt_ts;
    logic [N-1:0][TBW-1:0]   tile_lvt_tb;
    logic [TSW-1:0]          gvt_ts;
    logic [TBW-1:0]          gvt_tb;
    logic                    gvt_valid;
    logic [EW-1:0]           gvt_epoch;
    logic                    gvt_err;

    int             n_assert;
    int             n_fail;
    int             cyc;
    logic [TSW-1:0] ts_v [N];
    logic [TBW-1:0] tb_v [N];

    gvt_sequencer #(
        .N_TILES(N), .TS_WIDTH(TSW), .TB_WIDTH(TBW),
        .EPOCH_WIDTH(EW), .LOG_GVT_PERIOD(LOGP)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .gvt_hold       (gvt_hold),
        .lvt_req        (lvt_req),
        .tile_lvt_valid (tile_lvt_valid),
        .tile_lvt_ts    (tile_lvt_ts),
        .tile_lvt_tb    (tile_lvt_tb),
        .gvt_ts         (gvt_ts),
        .gvt_tb         (gvt_tb),
        .gvt_valid      (gvt_valid),
        .gvt_epoch      (gvt_epoch),
        .gvt_err        (gvt_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_lvt_req"}, 64'(lvt_req), 0);
        chk({tag, "_gvt_ts"}, 64'(gvt_ts), 0);
        chk({tag, "_gvt_tb"}, 64'(gvt_tb), 0);
        chk({tag, "_gvt_valid"}, 64'(gvt_valid), 0);
        chk({tag, "_gvt_epoch"}, 64'(gvt_epoch), 0);
        chk({tag, "_gvt_err"}, 64'(gvt_err), 0);
    endtask

    // Ticks until lvt_req is seen high or the limit expires.
    task automatic wait_req(input int limit, output int cycles);
        cycles = 0;
        while (lvt_req !== 1'b1 && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    // Called in the lvt_req cycle: all tiles answer in the following cycle.
    task automatic respond_all;
        tick();
        chk("req_pulse", 64'(lvt_req), 0);
        tile_lvt_valid = '1;
        for (int i = 0; i < N; i++) begin
            tile_lvt_ts[i] = ts_v[i];
            tile_lvt_tb[i] = tb_v[i];
        end
        tick();
        tile_lvt_valid = '0;
    endtask

    // Called just after the edge that latched the last response.
    task automatic expect_publish(input string tag, input int old_ep,
                                  input logic [TSW-1:0] ets, input logic [TBW-1:0] etb,
                                  input int eep, input logic eerr);
        repeat (9) tick();
        chk({tag, "_early_epoch"}, 64'(gvt_epoch), 64'(old_ep));
        tick();
        chk({tag, "_gvt_ts"}, 64'(gvt_ts), 64'(ets));
        chk({tag, "_gvt_tb"}, 64'(gvt_tb), 64'(etb));
        chk({tag, "_gvt_valid"}, 64'(gvt_valid), 1);
        chk({tag, "_gvt_epoch"}, 64'(gvt_epoch), 64'(eep));
        chk({tag, "_gvt_err"}, 64'(gvt_err), 64'(eerr));
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        clk            = 1'b0;
        rstn           = 1'b0;
        gvt_hold       = 1'b0;
        tile_lvt_valid = '0;
        tile_lvt_ts    = '0;
        tile_lvt_tb    = '0;

        // Reset values
        repeat (3) tick();
        check_zero("reset");

        // First request 32 edges after release
        rstn = 1'b1;
        wait_req(300, cyc);
        chk("first_req_latency", 64'(cyc), 32);

        // Round 1: ts=10*i+5, tb=i -> {5,0}
        for (int i = 0; i < N; i++) begin
            ts_v[i] = TSW'(10 * i + 5);
            tb_v[i] = TBW'(i);
        end
        respond_all();
        expect_publish("r1", 0, 5, 0, 1, 1'b0);

        // Round 2: tie on ts broken by tb -> {7,2}; stray valid during REQ ignored
        wait_req(300, cyc);
        chk("r2_period", 64'(cyc), 32);
        for (int i = 0; i < N; i++) begin
            ts_v[i] = 100;
            tb_v[i] = 0;
        end
        ts_v[3] = 7; tb_v[3] = 9;
        ts_v[5] = 7; tb_v[5] = 2;
        tile_lvt_valid[0] = 1'b1;
        tile_lvt_ts[0]    = 0;
        tile_lvt_tb[0]    = 0;
        respond_all();
        expect_publish("r2", 1, 7, 2, 2, 1'b0);

        // Round 3: tile7 late, tile2 repeats with {1,1} -> first value {150,3}
        wait_req(300, cyc);
        chk("r3_period", 64'(cyc), 32);
        for (int i = 0; i < N; i++) begin
            ts_v[i] = TSW'(200 + i);
            tb_v[i] = TBW'(i);
        end
        ts_v[2] = 150; tb_v[2] = 3;
        ts_v[7] = 300; tb_v[7] = 0;
        tick();
        tile_lvt_valid = 8'h7F;
        for (int i = 0; i < N; i++) begin
            tile_lvt_ts[i] = ts_v[i];
            tile_lvt_tb[i] = tb_v[i];
        end
        tick();
        tile_lvt_valid = 8'h04;
        tile_lvt_ts[2] = 1;
        tile_lvt_tb[2] = 1;
        tick();
        tile_lvt_valid = '0;
        repeat (48) tick();
        chk("r3_wait_epoch", 64'(gvt_epoch), 2);
        chk("r3_wait_gvt_ts", 64'(gvt_ts), 7);
        tile_lvt_valid = 8'h80;
        tile_lvt_ts[7] = ts_v[7];
        tile_lvt_tb[7] = tb_v[7];
        tick();
        tile_lvt_valid = '0;
        expect_publish("r3", 2, 150, 3, 3, 1'b0);

        // Round 4: every tile at infinity
        wait_req(300, cyc);
        chk("r4_period", 64'(cyc), 32);
        for (int i = 0; i < N; i++) begin
            ts_v[i] = '1;
            tb_v[i] = '1;
        end
        respond_all();
        expect_publish("r4", 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1'b0);

        // Reset in the middle of COLLECT
        wait_req(300, cyc);
        tick();
        tile_lvt_valid = 8'h0F;
        for (int i = 0; i < N; i++) begin
            tile_lvt_ts[i] = 1;
            tile_lvt_tb[i] = 1;
        end
        tick();
        tile_lvt_valid = '0;
        rstn = 1'b0;
        tick();
        check_zero("mid_reset");
        rstn = 1'b1;
        wait_req(300, cyc);
        chk("post_reset_req_latency", 64'(cyc), 32);

        // Monotonicity: min 20 then min 15
        for (int i = 0; i < N; i++) begin
            ts_v[i] = TSW'(20 + 3 * i);
            tb_v[i] = 0;
        end
        respond_all();
        expect_publish("mono_a", 0, 20, 0, 1, 1'b0);
        wait_req(300, cyc);
        chk("mono_b_period", 64'(cyc), 32);
        for (int i = 0; i < N; i++) begin
            ts_v[i] = TSW'(15 + i);
            tb_v[i] = 0;
        end
        respond_all();
        expect_publish("mono_b", 1, MONO ? 32'd20 : 32'd15, 0, 2, MONO);

        // gvt_hold for 100 cycles in IDLE delays the request by 100
        gvt_hold = 1'b1;
        repeat (100) tick();
        gvt_hold = 1'b0;
        wait_req(300, cyc);
        chk("hold_req_latency", 64'(cyc + 100), 132);
        for (int i = 0; i < N; i++) begin
            ts_v[i] = 20;
            tb_v[i] = 0;
        end
        respond_all();
        expect_publish("hold_round", 2, 20, 0, 3, MONO);

        // Epoch wraps to 0 after 253 more publishes
        for (int r = 0; r < 253; r++) begin
            wait_req(40, cyc);
            if (cyc >= 40) break;
            respond_all();
            repeat (10) tick();
        end
        chk("wrap_epoch", 64'(gvt_epoch), 0);
        chk("wrap_gvt_valid", 64'(gvt_valid), 1);
        chk("wrap_gvt_ts", 64'(gvt_ts), 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
